fetch_unit: RTL and testbench

//  Owns PC, instruction register (IR) and memory data register (MDR) for the multicycle MIPS core.

---
 rtl/fetch_unit_pkg.sv | 49 ++++
 rtl/fetch_unit_mem_handshake.sv | 125 ++++++++++++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the multicycle MIPS fetch unit: handshake
// states, PC source codes, opcode/funct constants and the jump-target helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    MIdle = 2'd0,
    MBusy = 2'd1,
    MDone = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'b00,
    PcSrcAluOut = 2'b01,
    PcSrcJump   = 2'b10,
    PcSrcRsvd   = 2'b11
  } pc_src_e;

  typedef enum logic [3:0] {
    InstFetch     = 4'd0,
    InstDecode    = 4'd1,
    InstMemAddr   = 4'd2,
    InstMemRead   = 4'd3,
    InstWriteBack = 4'd4,
    InstMemWrite  = 4'd5,
    InstExecute   = 4'd6,
    InstRtypeDone = 4'd7,
    InstBranch    = 4'd8,
    InstJump      = 4'd9
  } inst_state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] FunctJr = 6'h08;

  // pc_hi comes from the already-incremented PC.
  function automatic logic [31:0] jump_target(input logic [31:0] ir,
                                              input logic [3:0]  pc_hi,
                                              input logic [31:0] rs_val);
    if (ir[31:26] == OpRtype && ir[5:0] == FunctJr) begin
      return rs_val;
    end
    return {pc_hi, ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_mem_handshake.sv
// Memory request/acknowledge FSM with timeout, request registers, read
// buffer, stall generation and sticky bus error flags.
module fetch_unit_mem_handshake
  import fetch_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        i_access,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_done_rd,
  output logic [31:0] o_rbuf,
  output logic [1:0]  o_bus_err
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW:0] TimeoutVal = MEM_TIMEOUT[CntW:0];
  localparam logic [CntW:0] CntOne = {{CntW{1'b0}}, 1'b1};

  mem_state_e      r_state, w_state_d;
  logic            r_req, r_we;
  logic [31:0]     r_addr, r_wdata, r_rbuf;
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_err;
  logic [CntW:0]   w_cnt_inc;
  logic            w_cnt_hit, w_start, w_ack_take, w_timeout, w_misalign, w_stall;

  // Count includes the current BUSY cycle, so the abort fires on the Nth one.
  assign w_cnt_inc = {1'b0, r_cnt} + CntOne;
  assign w_cnt_hit = (MEM_TIMEOUT != 0) && (w_cnt_inc == TimeoutVal);

  always_comb begin
    w_state_d  = r_state;
    w_stall    = 1'b0;
    w_start    = 1'b0;
    w_misalign = 1'b0;
    w_ack_take = 1'b0;
    w_timeout  = 1'b0;
    unique case (r_state)
      MIdle: begin
        if (i_access) begin
          if (i_addr[1:0] == 2'b00) begin
            w_start   = 1'b1;
            w_stall   = 1'b1;
            w_state_d = MBusy;
          end else begin
            w_misalign = 1'b1;
          end
        end
      end
      MBusy: begin
        w_stall = 1'b1;
        if (i_mem_ack) begin
          w_ack_take = 1'b1;
          w_state_d  = MDone;
        end else if (w_cnt_hit) begin
          w_timeout = 1'b1;
          w_state_d = MDone;
        end
      end
      MDone:   w_state_d = MIdle;
      default: w_state_d = MIdle;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      r_state <= MIdle;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_cnt   <= '0;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_ack_take) begin
        r_req  <= 1'b0;
        r_rbuf <= i_mem_rdata;
      end
      if (w_timeout) begin
        r_req    <= 1'b0;
        r_rbuf   <= '0;
        r_err[0] <= 1'b1;
      end
      if (w_misalign) begin
        r_err[1] <= 1'b1;
      end
      if (r_state == MBusy) begin
        r_cnt <= w_cnt_inc[CntW-1:0];
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_stall     = w_stall;
  assign o_misalign  = w_misalign;
  assign o_done_rd   = (r_state == MDone) && !r_we;
  assign o_rbuf      = r_rbuf;
  assign o_bus_err   = r_err;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit for the multicycle MIPS core: PC, IR and MDR registers, address
// and jump-target muxes, and the memory port via the handshake FSM.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        PcWrite,
  input  logic [1:0]  PcWriteCond,
  input  logic [1:0]  PcSource,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IrWrite,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic        zero,
  input  logic [31:0] a_reg,
  input  logic [31:0] b_reg,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] I,
  output logic [31:0] pc,
  output logic [31:0] mdr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic        stall,
  output logic [1:0]  bus_err
);

  logic [31:0] r_pc, r_ir, r_mdr;
  logic [31:0] w_addr, w_rbuf, w_jump, w_pc_next;
  logic        w_access, w_stall, w_misalign, w_done_rd, w_pc_cond, w_pc_en;

  assign w_access = MemRead | MemWrite;
  assign w_addr   = IorD ? alu_out : r_pc;
  assign w_jump   = jump_target(r_ir, r_pc[31:28], a_reg);

  fetch_unit_mem_handshake #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_handshake (
    .cclk        (cclk),
    .rstb        (rstb),
    .i_access    (w_access),
    .i_we        (MemWrite),
    .i_addr      (w_addr),
    .i_wdata     (b_reg),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_stall     (w_stall),
    .o_misalign  (w_misalign),
    .o_done_rd   (w_done_rd),
    .o_rbuf      (w_rbuf),
    .o_bus_err   (bus_err)
  );

  always_comb begin
    w_pc_next = r_pc;
    unique case (pc_src_e'(PcSource))
      PcSrcAlu:    w_pc_next = alu_result;
      PcSrcAluOut: w_pc_next = alu_out;
      PcSrcJump:   w_pc_next = w_jump;
      PcSrcRsvd:   w_pc_next = r_pc;
      default:     w_pc_next = r_pc;
    endcase
  end

  // A rejected misaligned access must leave the PC untouched even though it does not stall.
  assign w_pc_cond = PcWrite | (PcWriteCond[0] & zero) | (PcWriteCond[1] & ~zero);
  assign w_pc_en   = ~w_stall & ~w_misalign & w_pc_cond & (PcSource != PcSrcRsvd);

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
      r_mdr <= '0;
    end else begin
      if (w_pc_en) begin
        r_pc <= w_pc_next;
      end
      if (w_done_rd) begin
        r_mdr <= w_rbuf;
        if (IrWrite) begin
          r_ir <= w_rbuf;
        end
      end
    end
  end

  assign I     = r_ir;
  assign pc    = r_pc;
  assign mdr   = r_mdr;
  assign stall = w_stall;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each control step queues its expected
// outcome; a monitor checks it when the DUT completes that step.
module tb_fetch_unit;

  typedef struct {
    string       name;
    bit          rst;
    bit          chk_cnt;
    bit          chk_addr;
    int          n_stall;
    int          n_req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [1:0]  err;
  } exp_t;

  logic        cclk = 1'b0;
  logic        rstb;
  logic        PcWrite, IorD, MemRead, MemWrite, IrWrite, zero, mem_ack;
  logic [1:0]  PcWriteCond, PcSource;
  logic [31:0] alu_result, alu_out, a_reg, b_reg, mem_rdata;

  logic [31:0] i_a, pc_a, mdr_a, addr_a, wdata_a, i_t, pc_t, mdr_t, addr_t, wdata_t;
  logic        req_a, we_a, stall_a, req_t, we_t, stall_t;
  logic [1:0]  err_a, err_t;

  logic        sel_t;
  logic [31:0] m_ir, m_pc, m_mdr, m_addr, m_wdata;
  logic        m_req, m_we, m_stall;
  logic [1:0]  m_err;

  int   checks = 0;
  int   fails = 0;
  int   ack_wait = 0;
  bit   force_ack = 1'b0;
  exp_t exp_q[$];

  always #5 cclk = ~cclk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(255)) dut (
    .cclk(cclk), .rstb(rstb), .PcWrite(PcWrite), .PcWriteCond(PcWriteCond),
    .PcSource(PcSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IrWrite(IrWrite), .alu_result(alu_result), .alu_out(alu_out), .zero(zero),
    .a_reg(a_reg), .b_reg(b_reg), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .I(i_a), .pc(pc_a), .mdr(mdr_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_req(req_a), .mem_we(we_a), .stall(stall_a), .bus_err(err_a)
  );

  fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(4)) dut_to (
    .cclk(cclk), .rstb(rstb), .PcWrite(PcWrite), .PcWriteCond(PcWriteCond),
    .PcSource(PcSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IrWrite(IrWrite), .alu_result(alu_result), .alu_out(alu_out), .zero(zero),
    .a_reg(a_reg), .b_reg(b_reg), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .I(i_t), .pc(pc_t), .mdr(mdr_t), .mem_addr(addr_t), .mem_wdata(wdata_t),
    .mem_req(req_t), .mem_we(we_t), .stall(stall_t), .bus_err(err_t)
  );

  assign m_ir    = sel_t ? i_t     : i_a;
  assign m_pc    = sel_t ? pc_t    : pc_a;
  assign m_mdr   = sel_t ? mdr_t   : mdr_a;
  assign m_addr  = sel_t ? addr_t  : addr_a;
  assign m_wdata = sel_t ? wdata_t : wdata_a;
  assign m_req   = sel_t ? req_t   : req_a;
  assign m_we    = sel_t ? we_t    : we_a;
  assign m_stall = sel_t ? stall_t : stall_a;
  assign m_err   = sel_t ? err_t   : err_a;

  function automatic exp_t mk_step(input string name, input int nst, input int nrq,
                                   input logic [31:0] addr, input logic we,
                                   input logic [31:0] wdata, input logic [31:0] pc,
                                   input logic [31:0] ir, input logic [31:0] mdr,
                                   input logic [1:0] err);
    exp_t e;
    e.name = name; e.rst = 1'b0; e.chk_cnt = 1'b1; e.chk_addr = (nrq > 0);
    e.n_stall = nst; e.n_req = nrq; e.addr = addr; e.we = we; e.wdata = wdata;
    e.pc = pc; e.ir = ir; e.mdr = mdr; e.err = err;
    return e;
  endfunction

  function automatic exp_t mk_reset(input string name, input logic [31:0] pc);
    exp_t e;
    e = mk_step(name, 0, 0, 32'h0, 1'b0, 32'h0, pc, 32'h0, 32'h0, 2'b00);
    e.rst = 1'b1; e.chk_cnt = 1'b0; e.chk_addr = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Memory model: ack after ack_wait request cycles (0 = never), or a forced stray ack.
  initial begin
    int rcnt;
    rcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge cclk);
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack = 1'b1;
        rcnt = 0;
      end else if (m_req === 1'b1) begin
        rcnt++;
        if (ack_wait != 0 && rcnt == ack_wait) mem_ack = 1'b1;
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: a step completes on a reset cycle or on an active, non-stalled cycle.
  initial begin
    int          nst, nrq;
    bit          stable, active;
    logic [31:0] a0, wd0;
    logic        we0;
    exp_t        e;
    nst = 0; nrq = 0; stable = 1'b1; a0 = '0; wd0 = '0; we0 = 1'b0;
    forever begin
      @(negedge cclk);
      if (m_req === 1'b1) begin
        if (nrq == 0) begin
          a0 = m_addr; we0 = m_we; wd0 = m_wdata;
        end else if (m_addr !== a0 || m_we !== we0 || m_wdata !== wd0) begin
          stable = 1'b0;
        end
        nrq++;
      end
      if (m_stall === 1'b1) nst++;
      active = PcWrite | (|PcWriteCond) | MemRead | MemWrite;
      if (rstb === 1'b0 || (m_stall === 1'b0 && active)) begin
        @(posedge cclk);
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_step: got a completed step, expected none");
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "/pc"}, m_pc, e.pc);
          chk({e.name, "/ir"}, m_ir, e.ir);
          chk({e.name, "/mdr"}, m_mdr, e.mdr);
          chk({e.name, "/bus_err"}, {30'b0, m_err}, {30'b0, e.err});
          chk({e.name, "/mem_req_after"}, {31'b0, m_req}, 32'h0);
          if (e.rst) chk({e.name, "/mem_we"}, {31'b0, m_we}, 32'h0);
          if (e.chk_cnt) begin
            chk({e.name, "/stall_cycles"}, 32'(nst), 32'(e.n_stall));
            chk({e.name, "/req_cycles"}, 32'(nrq), 32'(e.n_req));
          end
          if (e.chk_addr) begin
            chk({e.name, "/mem_addr"}, a0, e.addr);
            chk({e.name, "/mem_we"}, {31'b0, we0}, {31'b0, e.we});
            chk({e.name, "/mem_wdata"}, wd0, e.wdata);
            chk({e.name, "/req_stable"}, {31'b0, stable}, 32'h1);
          end
        end
        nst = 0; nrq = 0; stable = 1'b1;
      end
    end
  end

  task automatic set_ctrl(input logic pcw, input logic [1:0] pcwc, input logic [1:0] psrc,
                          input logic iord, input logic mr, input logic mw, input logic irw);
    PcWrite = pcw; PcWriteCond = pcwc; PcSource = psrc;
    IorD = iord; MemRead = mr; MemWrite = mw; IrWrite = irw;
  endtask

  task automatic do_reset(input exp_t e);
    exp_q.push_back(e);
    rstb = 1'b0;
    @(negedge cclk);
    @(posedge cclk);
    #2;
    rstb = 1'b1;
  endtask

  // Holds the controls until the DUT stops stalling, as the control unit would.
  task automatic do_step(input exp_t e, input logic pcw, input logic [1:0] pcwc,
                         input logic [1:0] psrc, input logic iord, input logic mr,
                         input logic mw, input logic irw);
    int n;
    bit done;
    exp_q.push_back(e);
    set_ctrl(pcw, pcwc, psrc, iord, mr, mw, irw);
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge cclk);
      if (m_stall === 1'b0) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 40) begin
          checks++;
          fails++;
          $display("FAIL %s/step_done: got stall for %0d cycles, expected release", e.name, n);
          void'(exp_q.pop_back());
          done = 1'b1;
        end
      end
    end
    @(posedge cclk);
    #2;
    set_ctrl(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected summary");
    $fatal(1);
  end

  initial begin
    rstb = 1'b0; sel_t = 1'b0; zero = 1'b0;
    set_ctrl(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    alu_result = 32'h0; alu_out = 32'h0; a_reg = 32'h0; b_reg = 32'h1111_1111;
    mem_rdata = 32'h0;

    do_reset(mk_reset("reset", 32'h0));

    alu_result = 32'h4; mem_rdata = 32'h8C41_0004; ack_wait = 1;
    do_step(mk_step("fetch_w0", 2, 1, 32'h0, 1'b0, 32'h1111_1111, 32'h4, 32'h8C41_0004,
                    32'h8C41_0004, 2'b00), 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);

    alu_result = 32'h8; mem_rdata = 32'h03E0_0008; ack_wait = 5;
    do_step(mk_step("fetch_w5", 6, 5, 32'h4, 1'b0, 32'h1111_1111, 32'h8, 32'h03E0_0008,
                    32'h03E0_0008, 2'b00), 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);

    a_reg = 32'h100;
    do_step(mk_step("jr", 0, 0, 32'h0, 1'b0, 32'h0, 32'h100, 32'h03E0_0008, 32'h03E0_0008,
                    2'b00), 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_out = 32'h40; zero = 1'b1;
    do_step(mk_step("beq_taken", 0, 0, 32'h0, 1'b0, 32'h0, 32'h40, 32'h03E0_0008,
                    32'h03E0_0008, 2'b00), 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_out = 32'h80; zero = 1'b0;
    do_step(mk_step("beq_not_taken", 0, 0, 32'h0, 1'b0, 32'h0, 32'h40, 32'h03E0_0008,
                    32'h03E0_0008, 2'b00), 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_out = 32'h60; zero = 1'b0;
    do_step(mk_step("bne_taken", 0, 0, 32'h0, 1'b0, 32'h0, 32'h60, 32'h03E0_0008,
                    32'h03E0_0008, 2'b00), 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_result = 32'h7777_0000;
    do_step(mk_step("pcsrc_rsvd", 0, 0, 32'h0, 1'b0, 32'h0, 32'h60, 32'h03E0_0008,
                    32'h03E0_0008, 2'b00), 1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_out = 32'h1000_0000; zero = 1'b1;
    do_step(mk_step("beq_far", 0, 0, 32'h0, 1'b0, 32'h0, 32'h1000_0000, 32'h03E0_0008,
                    32'h03E0_0008, 2'b00), 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_result = 32'h1000_0004; mem_rdata = 32'h0800_0010; ack_wait = 2; zero = 1'b0;
    do_step(mk_step("fetch_j", 3, 2, 32'h1000_0000, 1'b0, 32'h1111_1111, 32'h1000_0004,
                    32'h0800_0010, 32'h0800_0010, 2'b00),
            1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);

    do_step(mk_step("j", 0, 0, 32'h0, 1'b0, 32'h0, 32'h1000_0040, 32'h0800_0010,
                    32'h0800_0010, 2'b00), 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

    alu_out = 32'h2000_0008; mem_rdata = 32'hDEAD_BEEF; ack_wait = 1;
    do_step(mk_step("load", 2, 1, 32'h2000_0008, 1'b0, 32'h1111_1111, 32'h1000_0040,
                    32'h0800_0010, 32'hDEAD_BEEF, 2'b00),
            1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    alu_out = 32'h300; b_reg = 32'hCAFE_F00D; mem_rdata = 32'h5A5A_5A5A;
    do_step(mk_step("store", 2, 1, 32'h300, 1'b1, 32'hCAFE_F00D, 32'h1000_0040,
                    32'h0800_0010, 32'hDEAD_BEEF, 2'b00),
            1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);

    alu_out = 32'h202; alu_result = 32'h5555_0000;
    do_step(mk_step("store_misaligned", 0, 0, 32'h0, 1'b0, 32'h0, 32'h1000_0040,
                    32'h0800_0010, 32'hDEAD_BEEF, 2'b10),
            1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);

    do_reset(mk_reset("reset_clears_err", 32'h0));

    // Reset while BUSY, then a stray ack the cycle after.
    alu_result = 32'h4; mem_rdata = 32'h1234_5678; ack_wait = 0;
    set_ctrl(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge cclk);
    #2;
    set_ctrl(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(mk_reset("reset_in_busy", 32'h0));
    force_ack = 1'b1;
    @(posedge cclk);
    #2;
    force_ack = 1'b0;
    alu_result = 32'h8;
    do_step(mk_step("late_ack_ignored", 0, 0, 32'h0, 1'b0, 32'h0, 32'h8, 32'h0, 32'h0, 2'b00),
            1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout instance (MEM_TIMEOUT=4).
    sel_t = 1'b1;
    do_reset(mk_reset("reset_to", 32'h0));
    alu_result = 32'h4; mem_rdata = 32'h9999_9999; ack_wait = 0;
    do_step(mk_step("timeout", 5, 4, 32'h0, 1'b0, 32'hCAFE_F00D, 32'h4, 32'h0, 32'h0, 2'b01),
            1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);

    alu_out = 32'h1;
    do_step(mk_step("err_sticky", 0, 0, 32'h0, 1'b0, 32'h0, 32'h4, 32'h0, 32'h0, 2'b11),
            1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);

    repeat (3) @(posedge cclk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
